// File: rtl/pipeline_freeze_ctrl.sv
// Pipeline freeze/flush controller for a 5-stage core with a slow SRAM port.
// A MEM-stage access freezes the whole pipeline until the SRAM answers or a
// wait budget runs out. Taken branches flush IF/ID and ID/EX. ID hazards
// stall the front end. Memory freeze has priority over branch flush, which
// has priority over the hazard stall.
//
// Parameters
//   TIMEOUT  maximum WAIT cycles tolerated per memory access
//   CNT_W    width of the freeze-cycle performance counter
// Ports
//   clk            clock; all state updates on the rising edge
//   rst            synchronous active-low reset
//   mem_req        MEM stage holds a load/store that needs the SRAM
//   sram_ready     SRAM completes the current access this cycle
//   branch_taken   EX stage resolved a taken branch
//   hazard         ID stage data hazard
//   freeze_*       hold the named pipeline register (combinational)
//   flush_*        load a NOP into the named pipeline register (combinational)
//   sram_req       registered access request to the SRAM side
//   busy           access in flight (state is not IDLE)
//   mem_timeout    sticky timeout error flag; cleared only by reset
//   freeze_cycles  saturating count of cycles with freeze_mem high
module pipeline_freeze_ctrl #(
    parameter logic [7:0]  TIMEOUT = 8'd255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             branch_taken,
    input  logic             hazard,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_ex,
    output logic             freeze_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             sram_req,
    output logic             busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] freeze_cycles
);

    localparam int unsigned WAIT_W       = 8;
    localparam logic [7:0]  TIMEOUT_LAST = TIMEOUT - 8'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    state_t              state_eff;
    logic                timeout_hit;
    logic                mem_freeze;
    logic [WAIT_W-1:0]   wait_count;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the wait budget is checked before this cycle's increment.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (sram_ready) begin
                    state_nxt = DONE;
                end else if (wait_count == TIMEOUT_LAST) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // While reset is held the control outputs behave as if the FSM were IDLE.
    always_comb begin
        state_eff = rst ? state : IDLE;
    end

    // Freeze/flush decode: memory freeze > branch flush > hazard stall.
    always_comb begin
        freeze_if   = 1'b0;
        freeze_id   = 1'b0;
        freeze_ex   = 1'b0;
        freeze_mem  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        mem_freeze  = ((state_eff == IDLE) && mem_req) || (state_eff == WAIT);
        busy        = (state_eff != IDLE);
        if (mem_freeze) begin
            // EX/ID are held, so branch/hazard stay stable and are seen later.
            freeze_if  = 1'b1;
            freeze_id  = 1'b1;
            freeze_ex  = 1'b1;
            freeze_mem = 1'b1;
        end else if (branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (hazard) begin
            freeze_if   = 1'b1;
            freeze_id   = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    // Wait counter: cleared on entry to WAIT, counts cycles without ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_count <= '0;
        end else if ((state != WAIT) && (state_nxt == WAIT)) begin
            wait_count <= '0;
        end else if ((state == WAIT) && !sram_ready) begin
            wait_count <= wait_count + WAIT_W'(1);
        end
    end

    // SRAM request is high exactly in WAIT cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_req <= 1'b0;
        end else begin
            sram_req <= (state_nxt == WAIT);
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_timeout <= 1'b0;
        end else if (timeout_hit) begin
            mem_timeout <= 1'b1;
        end
    end

    // Saturating freeze-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            freeze_cycles <= '0;
        end else if (mem_freeze && (freeze_cycles != {CNT_W{1'b1}})) begin
            freeze_cycles <= freeze_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_freeze_ctrl.sv
// Self-checking bench for pipeline_freeze_ctrl (TIMEOUT=4, CNT_W=5).
module tb_pipeline_freeze_ctrl;

    localparam int TMO    = 4;
    localparam int CW     = 5;
    localparam int FC_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, mem_req, sram_ready, branch_taken, hazard;
    logic          freeze_if, freeze_id, freeze_ex, freeze_mem;
    logic          flush_if_id, flush_id_ex, sram_req, busy, mem_timeout;
    logic [CW-1:0] freeze_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    pipeline_freeze_ctrl #(.TIMEOUT(8'd4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .sram_ready(sram_ready),
        .branch_taken(branch_taken), .hazard(hazard),
        .freeze_if(freeze_if), .freeze_id(freeze_id), .freeze_ex(freeze_ex),
        .freeze_mem(freeze_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .sram_req(sram_req), .busy(busy), .mem_timeout(mem_timeout),
        .freeze_cycles(freeze_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: an access is "in wait" or "completing"; otherwise idle.
    bit m_wait = 0, m_done = 0, m_to = 0;
    int m_waited = 0, m_fc = 0;
    bit idle_now, mf_now;

    always @(posedge clk) begin
        cycle++;
        if (!rst) begin
            m_wait = 0; m_done = 0; m_to = 0; m_waited = 0; m_fc = 0;
        end else begin
            idle_now = !m_wait && !m_done;
            mf_now   = (idle_now && mem_req) || m_wait;
            if (mf_now) m_fc = (m_fc + 1 > FC_MAX) ? FC_MAX : m_fc + 1;
            if (m_done) begin
                m_done = 0;
            end else if (m_wait) begin
                if (sram_ready) begin
                    m_wait = 0; m_done = 1;
                end else if (m_waited + 1 == TMO) begin
                    m_wait = 0; m_done = 1; m_to = 1;
                end else begin
                    m_waited++;
                end
            end else if (mem_req) begin
                m_wait = 1; m_waited = 0;
            end
        end
    end

    // Expected {freeze_if,freeze_id,freeze_ex,freeze_mem,flush_if_id,flush_id_ex,sram_req,busy,mem_timeout}
    function automatic logic [8:0] expected_vec();
        bit w, d, mf;
        logic [5:0] ctl;
        w  = rst && m_wait;
        d  = rst && m_done;
        mf = (!w && !d && mem_req) || w;
        if (mf)                ctl = 6'b111100;
        else if (branch_taken) ctl = 6'b000011;
        else if (hazard)       ctl = 6'b110001;
        else                   ctl = 6'b000000;
        return {ctl, m_wait, w || d, m_to};
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [8:0] act, exp_v;
        act   = {freeze_if, freeze_id, freeze_ex, freeze_mem, flush_if_id, flush_id_ex,
                 sram_req, busy, mem_timeout};
        exp_v = expected_vec();
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: actual %b required %b", cycle, act, exp_v);
        end
        n_checks++;
        if (int'(freeze_cycles) != m_fc) begin
            n_fail++;
            $display("FAIL freeze_cycles cycle %0d: actual %0d required %0d", cycle, freeze_cycles, m_fc);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %0d required %0d", name, cycle, act, exp_v);
        end
    endtask

    // One cycle: drive inputs after the edge, return once outputs have settled.
    task automatic cyc(input logic r, input logic m, input logic s, input logic b, input logic h);
        @(posedge clk);
        #1;
        rst = r; mem_req = m; sram_ready = s; branch_taken = b; hazard = h;
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 0; mem_req = 0; sram_ready = 0; branch_taken = 0; hazard = 0;
        repeat (2) cyc(0, 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sram_req", sram_req, 0);
        chk("reset_timeout", mem_timeout, 0);
        chk("reset_fc", freeze_cycles, 0);
        // Combinational decode still active under reset, as if IDLE.
        cyc(0, 1, 0, 0, 0);
        chk("rst_mem_freeze", freeze_mem, 1);
        chk("rst_busy", busy, 0);
        cyc(0, 0, 0, 1, 0);
        chk("rst_branch_flush", flush_if_id, 1);

        // Access completing on the third WAIT cycle.
        cyc(1, 1, 0, 0, 0);
        chk("acc_c0_freeze", freeze_mem, 1);
        chk("acc_c0_sram_req", sram_req, 0);
        cyc(1, 0, 0, 0, 0);
        chk("acc_c1_sram_req", sram_req, 1);
        chk("acc_c1_busy", busy, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("acc_c3_freeze_if", freeze_if, 1);
        cyc(1, 0, 0, 0, 0);
        chk("acc_done_freeze", freeze_mem, 0);
        chk("acc_done_busy", busy, 1);
        chk("acc_done_sram_req", sram_req, 0);
        chk("acc_fc4", freeze_cycles, 4);
        cyc(1, 0, 0, 0, 0);
        chk("acc_idle_busy", busy, 0);

        // Branch beats hazard; hazard alone stalls the front end.
        cyc(1, 0, 0, 1, 1);
        chk("bh_flush_if_id", flush_if_id, 1);
        chk("bh_flush_id_ex", flush_id_ex, 1);
        chk("bh_freeze_if", freeze_if, 0);
        cyc(1, 0, 0, 0, 1);
        chk("hz_vec", {freeze_if, freeze_id, freeze_ex, freeze_mem, flush_if_id, flush_id_ex}, 6'b110001);

        // Branch held through WAIT is deferred to the DONE cycle.
        cyc(1, 1, 0, 1, 0);
        chk("br_wait_noflush0", flush_if_id, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        chk("br_wait_noflush2", flush_id_ex, 0);
        cyc(1, 0, 0, 1, 0);
        chk("br_done_vec", {freeze_if, freeze_mem, flush_if_id, flush_id_ex}, 4'b0011);
        cyc(1, 0, 0, 0, 0);

        // Timeout after four WAIT cycles; flag stays through a good access.
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < TMO; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("tmo_wait_sram_req", sram_req, 1);
            chk("tmo_wait_flag", mem_timeout, 0);
        end
        cyc(1, 0, 0, 0, 0);
        chk("tmo_done_sram_req", sram_req, 0);
        chk("tmo_done_flag", mem_timeout, 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("tmo_sticky", mem_timeout, 1);
        chk("tmo_after_busy", busy, 0);

        // Reset in the second WAIT cycle aborts with no DONE cycle.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("abort_sram_req", sram_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fc", freeze_cycles, 0);
        chk("abort_timeout", mem_timeout, 0);

        // Counter saturation: eight timed-out accesses, five freeze cycles each.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0, 0);
            repeat (TMO + 1) cyc(1, 0, 0, 0, 0);
        end
        chk("fc_saturated", freeze_cycles, FC_MAX);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0);
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_freeze_ctrl.md
PIPELINE_FREEZE_CTRL -- requirements
Module: pipeline_freeze_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8'd255, is the maximum number of WAIT cycles tolerated per memory access.
REQ-002 Parameter CNT_W, default 16, is the width of the freeze-cycle performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 mem_req  in  1  MEM stage holds a load/store needing SRAM.
REQ-006 sram_ready  in  1  SRAM side completes the current access this cycle.
REQ-007 branch_taken  in  1  EX stage resolved a taken branch.
REQ-008 hazard  in  1  ID stage data hazard detected.
REQ-009 freeze_if, freeze_id, freeze_ex, freeze_mem  out  1 each  hold the corresponding pipeline register.
REQ-010 flush_if_id, flush_id_ex  out  1 each  load NOP into the corresponding pipeline register.
REQ-011 sram_req  out  1  registered access request to SRAM side.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 mem_timeout  out  1  sticky timeout error flag.
REQ-014 freeze_cycles  out  CNT_W  saturating count of cycles with freeze_mem high.

Function
REQ-015 FSM states IDLE, WAIT, DONE shall be implemented; reset state is IDLE.
REQ-016 IDLE: mem_req=1 -> WAIT next cycle; otherwise remain IDLE.
REQ-017 WAIT: sram_ready=1 -> DONE; wait_count==TIMEOUT-1 with sram_ready=0 -> DONE with mem_timeout set; else remain WAIT.
REQ-018 DONE -> IDLE unconditionally after one cycle; mem_req is ignored in DONE.
REQ-019 The internal 8-bit wait_count shall clear on entry to WAIT and increment by 1 per WAIT cycle with sram_ready=0.
REQ-020 sram_req shall be registered: high in every WAIT cycle, low in IDLE and DONE.
REQ-021 mem_freeze = (IDLE & mem_req) | WAIT, combinational; all four freeze outputs shall be high when mem_freeze=1.
REQ-022 While mem_freeze=1, both flush outputs shall be 0; branch_taken and hazard are deferred, because EX/ID are held and keep them stable.
REQ-023 When mem_freeze=0 and branch_taken=1: flush_if_id=1, flush_id_ex=1, all freezes 0; hazard is ignored that cycle.
REQ-024 When mem_freeze=0, branch_taken=0 and hazard=1: freeze_if=1, freeze_id=1, flush_id_ex=1; freeze_ex=0, freeze_mem=0.
REQ-025 Priority shall be memory freeze > branch flush > hazard stall.
REQ-026 In DONE all freezes shall be 0, so the MEM instruction advances; branch/hazard rules REQ-023/024 apply in DONE.
REQ-027 mem_timeout shall stay set until reset; later accesses shall proceed normally.
REQ-028 freeze_cycles shall increment by 1 each cycle freeze_mem=1 and saturate at all-ones.
REQ-029 busy = (state != IDLE).

Reset
REQ-030 On rst=0 at a clock edge: state=IDLE, wait_count=0, sram_req=0, mem_timeout=0, freeze_cycles=0.
REQ-031 Reset asserted mid-WAIT shall abort the access: sram_req=0 the following cycle, with no DONE cycle.
REQ-032 While rst=0, combinational outputs shall still follow REQ-021..024, evaluated with state=IDLE.

Verification
REQ-033 mem_req=1 at cycle 0, sram_ready=1 at cycle 3 -> freezes high cycles 0-3, sram_req high cycles 1-3, DONE at 4, IDLE at 5, freeze_cycles=4.
REQ-034 mem_req=1, sram_ready never asserted, TIMEOUT=4 -> WAIT for 4 cycles, DONE, mem_timeout=1 and remains 1 through a following normal access.
REQ-035 branch_taken=1 and hazard=1 together in IDLE with mem_req=0 -> flush_if_id=1, flush_id_ex=1, all freezes 0.
REQ-036 hazard=1 alone -> freeze_if=1, freeze_id=1, flush_id_ex=1, freeze_ex=0, freeze_mem=0.
REQ-037 branch_taken=1 held during WAIT -> no flush until the DONE cycle, then flush_if_id=1 and flush_id_ex=1 there.
REQ-038 rst=0 in the second WAIT cycle -> next cycle: state IDLE, sram_req=0, freeze_cycles=0, busy=0.
